cla_pipelined_adder: RTL



---
 rtl/cla_pipelined_adder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cla_pipelined_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage 1 forms bit and group generate/propagate; stage 2 resolves carries and flags.
module cla_pipelined_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned NG  = WIDTH / 4;
    localparam int unsigned GLW = 3 * NG;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
        $error("cla_pipelined_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    logic             s1_valid_d, s1_valid_q;
    logic             s2_valid_d, s2_valid_q;
    logic [WIDTH-1:0] p_d, p_q;
    // Only the low three generates of each group feed bit carries; the top one lives in GG.
    logic [GLW-1:0]   g_lo_d, g_lo_q;
    logic [NG-1:0]    gg_d, gg_q;
    logic [NG-1:0]    pg_d, pg_q;
    logic             c_eff_d, c_eff_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    logic             s1_adv;
    logic             accept;
    logic             s2_load;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g_all;
    logic [WIDTH-1:0] p_all;
    logic [NG:0]      c_grp;
    logic [WIDTH-1:0] c_bit;
    logic [WIDTH-1:0] sum_c;

    // Handshake: an empty stage always advances, so bubbles collapse.
    always_comb begin
        s1_adv   = ~s2_valid_q | out_ready;
        in_ready = ~s1_valid_q | s1_adv;
        accept   = in_valid & in_ready;
        s2_load  = s1_adv & s1_valid_q;
    end

    // Stage 1: bit and group generate/propagate.
    always_comb begin
        b_eff  = sub ? ~b : b;
        g_all  = a & b_eff;
        p_all  = a ^ b_eff;
        gg_d   = gg_q;
        pg_d   = pg_q;
        g_lo_d = g_lo_q;
        p_d    = accept ? p_all : p_q;
        c_eff_d    = accept ? (cin ^ sub) : c_eff_q;
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        if (accept) begin
            for (int k = 0; k < NG; k++) begin
                gg_d[k] = g_all[4*k+3]
                        | (p_all[4*k+3] & g_all[4*k+2])
                        | (p_all[4*k+3] & p_all[4*k+2] & g_all[4*k+1])
                        | (p_all[4*k+3] & p_all[4*k+2] & p_all[4*k+1] & g_all[4*k]);
                pg_d[k] = &p_all[4*k +: 4];
                g_lo_d[3*k +: 3] = g_all[4*k +: 3];
            end
        end
    end

    // Stage 2: flattened sum-of-products carries at group level, then inside each group.
    always_comb begin
        logic gen;
        logic prop;
        gen   = 1'b0;
        prop  = 1'b0;
        c_grp = '0;
        c_bit = '0;
        c_grp[0] = c_eff_q;
        for (int k = 0; k < NG; k++) begin
            gen  = gg_q[k];
            prop = pg_q[k];
            for (int j = k - 1; j >= 0; j--) begin
                gen  = gen | (prop & gg_q[j]);
                prop = prop & pg_q[j];
            end
            c_grp[k+1] = gen | (prop & c_eff_q);
        end
        for (int k = 0; k < NG; k++) begin
            c_bit[4*k] = c_grp[k];
            for (int i = 1; i < 4; i++) begin
                gen  = g_lo_q[3*k+i-1];
                prop = p_q[4*k+i-1];
                for (int j = i - 2; j >= 0; j--) begin
                    gen  = gen | (prop & g_lo_q[3*k+j]);
                    prop = prop & p_q[4*k+j];
                end
                c_bit[4*k+i] = gen | (prop & c_grp[k]);
            end
        end
        sum_c      = p_q ^ c_bit;
        s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
        sum_d      = s2_load ? sum_c : sum_q;
        cout_d     = s2_load ? c_grp[NG] : cout_q;
        ovf_d      = s2_load ? (c_grp[NG] ^ c_bit[WIDTH-1]) : ovf_q;
        zero_d     = s2_load ? ~|sum_c : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            p_q        <= '0;
            g_lo_q     <= '0;
            gg_q       <= '0;
            pg_q       <= '0;
            c_eff_q    <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            p_q        <= p_d;
            g_lo_q     <= g_lo_d;
            gg_q       <= gg_d;
            pg_q       <= pg_d;
            c_eff_q    <= c_eff_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
